// File: rtl/enigma_pkg.sv
// rtl/enigma_pkg.sv - shared constants, state encoding and helpers for the Enigma rotor sequencer
package enigma_pkg;

    localparam int         ALPHABET_SIZE = 26;
    localparam logic [4:0] MAX_POS       = 5'd25;

    // Default turnover notches: right = V, middle = E, left = Q
    localparam logic [4:0] NOTCH_R_DEFAULT = 5'd21;
    localparam logic [4:0] NOTCH_M_DEFAULT = 5'd4;
    localparam logic [4:0] NOTCH_L_DEFAULT = 5'd16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        STEP     = 2'd1,
        START    = 2'd2,
        WAIT_ENC = 2'd3
    } step_state_t;

    // Out-of-alphabet init values are replaced by 0 so no rotor ever leaves 0..25
    function automatic logic [4:0] clamp_pos(input logic [4:0] p);
        return (p > MAX_POS) ? 5'd0 : p;
    endfunction

endpackage

// File: rtl/rotor_pos_next.sv
// rtl/rotor_pos_next.sv - next rotor position with 25 -> 0 wrap when stepped
module rotor_pos_next
    import enigma_pkg::*;
(
    input  logic [4:0] pos,
    input  logic       step,
    output logic [4:0] pos_next
);

    // >= keeps the wrap safe even if an out-of-range value were ever presented
    always_comb begin
        pos_next = pos;
        if (step) begin
            pos_next = (pos >= MAX_POS) ? 5'd0 : pos + 5'd1;
        end
    end

endmodule

// File: rtl/enigma_step_controller.sv
// rtl/enigma_step_controller.sv - three-rotor stepping sequencer with encoder start/done handshake
module enigma_step_controller
    import enigma_pkg::*;
#(
    parameter logic [4:0] NOTCH_R = NOTCH_R_DEFAULT,
    parameter logic [4:0] NOTCH_M = NOTCH_M_DEFAULT,
    parameter logic [4:0] NOTCH_L = NOTCH_L_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_press,
    input  logic       load_init_state,
    input  logic [4:0] init_pos_l,
    input  logic [4:0] init_pos_m,
    input  logic [4:0] init_pos_r,
    input  logic       enc_done,
    output logic [7:0] pos_l,
    output logic [7:0] pos_m,
    output logic [7:0] pos_r,
    output logic       enc_start,
    output logic       busy,
    output logic       at_notch_l
);

    step_state_t state;
    logic [4:0]  rot_l, rot_m, rot_r;
    logic [4:0]  nxt_l, nxt_m, nxt_r;
    logic        step_m, step_l;

    // Middle steps on the right turnover and again on its own notch (double step)
    assign step_m = (rot_r == NOTCH_R) || (rot_m == NOTCH_M);
    assign step_l = (rot_m == NOTCH_M);

    rotor_pos_next u_rot_r (.pos(rot_r), .step(1'b1),   .pos_next(nxt_r));
    rotor_pos_next u_rot_m (.pos(rot_m), .step(step_m), .pos_next(nxt_m));
    rotor_pos_next u_rot_l (.pos(rot_l), .step(step_l), .pos_next(nxt_l));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            rot_l     <= 5'd0;
            rot_m     <= 5'd0;
            rot_r     <= 5'd0;
            enc_start <= 1'b0;
            busy      <= 1'b0;
        end else if (load_init_state) begin
            // Load aborts any encode in flight and drops a coincident key
            state     <= IDLE;
            rot_l     <= clamp_pos(init_pos_l);
            rot_m     <= clamp_pos(init_pos_m);
            rot_r     <= clamp_pos(init_pos_r);
            enc_start <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (key_press) begin
                        state <= STEP;
                        busy  <= 1'b1;
                    end
                end
                STEP: begin
                    rot_l     <= nxt_l;
                    rot_m     <= nxt_m;
                    rot_r     <= nxt_r;
                    state     <= START;
                    enc_start <= 1'b1;
                end
                START: begin
                    enc_start <= 1'b0;
                    state     <= WAIT_ENC;
                end
                WAIT_ENC: begin
                    if (enc_done) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    enc_start <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    assign pos_l      = {3'b000, rot_l};
    assign pos_m      = {3'b000, rot_m};
    assign pos_r      = {3'b000, rot_r};
    assign at_notch_l = (rot_l == NOTCH_L);

endmodule

// File: tb/tb_enigma_step_controller.sv
// tb/tb_enigma_step_controller.sv - randomized self-checking bench against an Enigma stepping model
module tb_enigma_step_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       key_press;
    logic       load_init_state;
    logic [4:0] init_pos_l, init_pos_m, init_pos_r;
    logic       enc_done;
    logic [7:0] pos_l, pos_m, pos_r;
    logic       enc_start, busy, at_notch_l;

    int n_checks = 0;
    int n_pass   = 0;
    int ml, mm, mr;

    always #5 clk = ~clk;

    enigma_step_controller dut (
        .clk            (clk),
        .reset          (reset),
        .key_press      (key_press),
        .load_init_state(load_init_state),
        .init_pos_l     (init_pos_l),
        .init_pos_m     (init_pos_m),
        .init_pos_r     (init_pos_r),
        .enc_done       (enc_done),
        .pos_l          (pos_l),
        .pos_m          (pos_m),
        .pos_r          (pos_r),
        .enc_start      (enc_start),
        .busy           (busy),
        .at_notch_l     (at_notch_l)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic check_pos(input string tag);
        check({tag, "_l"}, int'(pos_l), ml);
        check({tag, "_m"}, int'(pos_m), mm);
        check({tag, "_r"}, int'(pos_r), mr);
        check({tag, "_notch_l"}, int'(at_notch_l), (ml == 16) ? 1 : 0);
    endtask

    // Reference Enigma stepping: right always turns, V carries into middle, E double-steps
    task automatic model_step();
        bit sm, sl;
        sm = (mr == 21) || (mm == 4);
        sl = (mm == 4);
        mr = (mr + 1) % 26;
        if (sm) mm = (mm + 1) % 26;
        if (sl) ml = (ml + 1) % 26;
    endtask

    function automatic int clampv(input int v);
        return (v > 25) ? 0 : v;
    endfunction

    // Called just after a negedge; returns just after a negedge
    task automatic do_load(input int l, input int m, input int r, input bit with_key);
        int lv, mv, rv;
        lv = l; mv = m; rv = r;
        init_pos_l = lv[4:0];
        init_pos_m = mv[4:0];
        init_pos_r = rv[4:0];
        load_init_state = 1'b1;
        key_press = with_key;
        @(negedge clk);
        load_init_state = 1'b0;
        key_press = 1'b0;
        ml = clampv(l); mm = clampv(m); mr = clampv(r);
        check_pos("load");
        check("load_busy", int'(busy), 0);
        check("load_start", int'(enc_start), 0);
        @(negedge clk);
        check("load_busy2", int'(busy), 0);
        check("load_start2", int'(enc_start), 0);
        check_pos("load_hold");
    endtask

    task automatic do_key(input int wait_cycles, input bit stray, input bit early_done);
        int pulses;
        key_press = 1'b1;
        @(negedge clk);
        key_press = stray;
        check("step_busy", int'(busy), 1);
        check("step_start", int'(enc_start), 0);
        check_pos("pre_step");
        model_step();
        @(negedge clk);
        check("enc_start", int'(enc_start), 1);
        check_pos("post_step");
        enc_done = early_done;
        @(negedge clk);
        enc_done = 1'b0;
        pulses = 0;
        check("wait_busy", int'(busy), 1);
        for (int i = 0; i < wait_cycles; i++) begin
            if (enc_start) pulses++;
            @(negedge clk);
        end
        if (enc_start) pulses++;
        check("start_once", pulses, 0);
        check("wait_busy2", int'(busy), 1);
        enc_done = 1'b1;
        key_press = 1'b0;
        @(negedge clk);
        enc_done = 1'b0;
        check("done_busy", int'(busy), 0);
        check_pos("done");
        @(negedge clk);
        check("idle_busy", int'(busy), 0);
        check("idle_start", int'(enc_start), 0);
        check_pos("idle");
    endtask

    initial begin
        int sel, l, m, r;
        reset = 1'b1;
        key_press = 1'b0;
        load_init_state = 1'b0;
        enc_done = 1'b0;
        init_pos_l = '0; init_pos_m = '0; init_pos_r = '0;
        ml = 0; mm = 0; mr = 0;
        repeat (2) @(negedge clk);
        check_pos("reset");
        check("reset_busy", int'(busy), 0);
        check("reset_start", int'(enc_start), 0);
        reset = 1'b0;
        @(negedge clk);

        // Asynchronous reset while waiting for the encoder
        do_load(3, 7, 8, 1'b0);
        key_press = 1'b1;
        @(negedge clk);
        key_press = 1'b0;
        model_step();
        @(negedge clk);
        @(negedge clk);
        check_pos("pre_reset");
        check("pre_reset_busy", int'(busy), 1);
        #2 reset = 1'b1;
        #1;
        ml = 0; mm = 0; mr = 0;
        check_pos("async_reset");
        check("async_reset_busy", int'(busy), 0);
        check("async_reset_start", int'(enc_start), 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // ADU -> ADV -> AEW -> BFX (double step)
        do_load(0, 3, 20, 1'b0);
        repeat (3) do_key(1, 1'b0, 1'b0);
        check("adv_l", int'(pos_l), 1);
        check("adv_m", int'(pos_m), 5);
        check("adv_r", int'(pos_r), 23);

        do_load(30, 25, 26, 1'b0);
        do_key(0, 1'b0, 1'b0);
        check("clamp_m", int'(pos_m), 25);
        check("clamp_r", int'(pos_r), 1);

        do_load(25, 4, 25, 1'b0);
        do_key(2, 1'b0, 1'b0);
        check("wrap_l", int'(pos_l), 0);
        check("wrap_m", int'(pos_m), 5);
        check("wrap_r", int'(pos_r), 0);

        // Stray keys while busy and an enc_done during START are ignored
        do_key(3, 1'b1, 1'b1);

        // Load beats a coincident key
        do_load(16, 2, 9, 1'b1);

        // Load aborts an encode in flight; the late enc_done is ignored
        key_press = 1'b1;
        @(negedge clk);
        key_press = 1'b0;
        repeat (2) @(negedge clk);
        do_load(5, 21, 4, 1'b0);
        enc_done = 1'b1;
        @(negedge clk);
        enc_done = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_start", int'(enc_start), 0);
        check_pos("abort");

        for (int it = 0; it < 60; it++) begin
            sel = $urandom_range(0, 5);
            if (sel == 0) begin
                l = $urandom_range(0, 31);
                m = ($urandom_range(0, 1) == 1) ? $urandom_range(3, 4) : $urandom_range(0, 31);
                r = ($urandom_range(0, 1) == 1) ? $urandom_range(20, 21) : $urandom_range(0, 31);
                do_load(l, m, r, $urandom_range(0, 1) == 1);
            end else begin
                if (sel == 1) begin
                    enc_done = 1'b1;
                    @(negedge clk);
                    enc_done = 1'b0;
                    check("idle_done_busy", int'(busy), 0);
                end
                do_key($urandom_range(0, 4), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
